// File: rtl/contador_lotes_if.sv
// contador_lotes_if: control inputs and status outputs of the bottle/box
// lot counter. The master side (sensor logic / bench) drives start_proc,
// inc, dec and mode_wrap; the slave side (the counter) drives the counts,
// pulses, flags and FSM state.
interface contador_lotes_if #(
    parameter int BOT_W = 4,
    parameter int BOX_W = 4
) ();
    logic             start_proc;
    logic             inc;
    logic             dec;
    logic             mode_wrap;
    logic [BOT_W-1:0] bottles;
    logic [BOX_W-1:0] boxes;
    logic             box_done;
    logic             lot_done;
    logic             lot_full;
    logic             overflow;
    logic [1:0]       state;

    modport master (
        output start_proc, inc, dec, mode_wrap,
        input  bottles, boxes, box_done, lot_done, lot_full, overflow, state
    );

    modport slave (
        input  start_proc, inc, dec, mode_wrap,
        output bottles, boxes, box_done, lot_done, lot_full, overflow, state
    );
endinterface

// File: rtl/contador_lotes.sv
// contador_lotes: counts bottle pulses into boxes of BOTTLES_PER_BOX and
// completed boxes up to MAX_BOXES per lot, with reject removal (dec),
// wrap/saturate lot mode, lot-full flag and sticky overflow.
// Optional macro INC_EDGE_DETECT_EN: inc/dec are sensor levels and only a
// 0->1 transition counts (two-cycle latency through a delay register pair).
module contador_lotes #(
    parameter int BOTTLES_PER_BOX = 12,
    parameter int BOT_W           = 4,
    parameter int MAX_BOXES       = 9,
    parameter int BOX_W           = 4
) (
    input  logic            clk,
    input  logic            reset,
    contador_lotes_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [BOT_W-1:0] BOT_LAST = BOT_W'(BOTTLES_PER_BOX - 1);
    localparam logic [BOX_W-1:0] BOX_LAST = BOX_W'(MAX_BOXES);

    state_t           state_q, state_d;
    logic [BOT_W-1:0] bottles_q, bottles_d;
    logic [BOX_W-1:0] boxes_q, boxes_d;
    logic             box_done_q, box_done_d;
    logic             lot_done_q, lot_done_d;
    logic             lot_full_q, lot_full_d;
    logic             overflow_q, overflow_d;

    // Qualified count events after optional edge detection.
    logic inc_evt;
    logic dec_evt;

`ifdef INC_EDGE_DETECT_EN
    logic inc_d1_q, inc_d1_d, inc_d2_q, inc_d2_d;
    logic dec_d1_q, dec_d1_d, dec_d2_q, dec_d2_d;

    // Delay line for the sensor levels; a new lot forgets any pending edge.
    always_comb begin
        inc_d1_d = bus.inc;
        inc_d2_d = inc_d1_q;
        dec_d1_d = bus.dec;
        dec_d2_d = dec_d1_q;
        if (bus.start_proc) begin
            inc_d1_d = 1'b0;
            inc_d2_d = 1'b0;
            dec_d1_d = 1'b0;
            dec_d2_d = 1'b0;
        end
    end

    // Edge-detect delay registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_d1_q <= 1'b0;
            inc_d2_q <= 1'b0;
            dec_d1_q <= 1'b0;
            dec_d2_q <= 1'b0;
        end else begin
            inc_d1_q <= inc_d1_d;
            inc_d2_q <= inc_d2_d;
            dec_d1_q <= dec_d1_d;
            dec_d2_q <= dec_d2_d;
        end
    end

    assign inc_evt = inc_d1_q & ~inc_d2_q;
    assign dec_evt = dec_d1_q & ~dec_d2_q;
`else
    assign inc_evt = bus.inc;
    assign dec_evt = bus.dec;
`endif

    // Next-state and count logic; start_proc overrides any count event.
    always_comb begin
        state_d    = state_q;
        bottles_d  = bottles_q;
        boxes_d    = boxes_q;
        overflow_d = overflow_q;
        box_done_d = 1'b0;
        lot_done_d = 1'b0;

        if (bus.start_proc) begin
            state_d    = ST_IDLE;
            bottles_d  = '0;
            boxes_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (inc_evt && !dec_evt) begin
                        bottles_d = BOT_W'(1);
                        state_d   = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (inc_evt && !dec_evt) begin
                        if (bottles_q != BOT_LAST) begin
                            bottles_d = bottles_q + BOT_W'(1);
                        end else begin
                            bottles_d  = '0;
                            box_done_d = 1'b1;
                            if (boxes_q != BOX_LAST) begin
                                boxes_d = boxes_q + BOX_W'(1);
                                if ((boxes_q + BOX_W'(1)) == BOX_LAST && !bus.mode_wrap)
                                    state_d = ST_FULL;
                            end else if (bus.mode_wrap) begin
                                boxes_d    = '0;
                                lot_done_d = 1'b1;
                            end else begin
                                // Lot already at its last box when the mode
                                // switched to saturate: hold and go full.
                                state_d = ST_FULL;
                            end
                        end
                    end else if (dec_evt && !inc_evt && bottles_q != '0) begin
                        bottles_d = bottles_q - BOT_W'(1);
                    end
                end
                ST_FULL: begin
                    if (inc_evt && !dec_evt)
                        overflow_d = 1'b1;
                    if (bus.mode_wrap)
                        state_d = ST_COUNT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        lot_full_d = (state_d == ST_FULL);
    end

    // Counter, flag and state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bottles_q  <= '0;
            boxes_q    <= '0;
            box_done_q <= 1'b0;
            lot_done_q <= 1'b0;
            lot_full_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bottles_q  <= bottles_d;
            boxes_q    <= boxes_d;
            box_done_q <= box_done_d;
            lot_done_q <= lot_done_d;
            lot_full_q <= lot_full_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.bottles  = bottles_q;
    assign bus.boxes    = boxes_q;
    assign bus.box_done = box_done_q;
    assign bus.lot_done = lot_done_q;
    assign bus.lot_full = lot_full_q;
    assign bus.overflow = overflow_q;
    assign bus.state    = state_q;

endmodule

// File: doc/contador_lotes.md
Name: contador_lotes

Overview:
- Parametrised successor of the dozen counter for the wine-conveyor line.
- Counts bottle pulses into boxes of BOTTLES_PER_BOX, then counts completed boxes up to MAX_BOXES per lot.
- Supports removal of rejected bottles, a wrap or saturate lot mode, a lot-full flag and sticky overflow.
- Sits between the bottle-presence sensor logic and the 7-segment/display and conveyor-control FSM.

Parameters:
- BOTTLES_PER_BOX, 12, bottles per box (≥2).
- BOT_W, 4, width of bottle count; 2^BOT_W ≥ BOTTLES_PER_BOX.
- MAX_BOXES, 9, last valid box count in a lot (≥1).
- BOX_W, 4, width of box count; 2^BOX_W > MAX_BOXES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_proc  in  1  synchronous clear; starts a new lot.
- inc  in  1  bottle-arrived pulse.
- dec  in  1  rejected bottle removed from the current box.
- mode_wrap  in  1  1 = lot wraps to 0 after the last box; 0 = saturate at full.
- bottles  out  BOT_W  bottles in the current box.
- boxes  out  BOX_W  completed boxes in the current lot.
- box_done  out  1  one-cycle pulse, cycle after a box completes.
- lot_done  out  1  one-cycle pulse, cycle after a wrap (mode_wrap=1 only).
- lot_full  out  1  high in state FULL.
- overflow  out  1  sticky: an inc was dropped in FULL.
- state  out  2  FSM state: IDLE=0, COUNT=1, FULL=2.

Behaviour:
- reset low (async): bottles=0, boxes=0, all flags and pulses 0, state=IDLE. Holds while low; resumes on the first clk edge after release.
- Priority per cycle: reset > start_proc > (inc, dec).
- start_proc=1: bottles=0, boxes=0, overflow=0, pulses 0, state=IDLE; inc and dec are ignored that cycle.
- inc=1 and dec=1 in the same cycle: no count change; state unchanged.
- IDLE:
  - inc → bottles=1 (BOTTLES_PER_BOX=1 is not allowed), state=COUNT.
  - dec is ignored.
- COUNT, inc only:
  - bottles<BOTTLES_PER_BOX-1 → bottles+1.
  - bottles==BOTTLES_PER_BOX-1 → bottles=0 and box_done=1 next cycle, then:
    - boxes<MAX_BOXES → boxes+1; if the new value equals MAX_BOXES and mode_wrap=0, state=FULL.
    - boxes==MAX_BOXES (wrap mode only) → boxes=0, lot_done=1 next cycle, state stays COUNT.
- COUNT, dec only:
  - bottles>0 → bottles-1.
  - bottles==0 → ignored; never borrows from boxes, never underflows.
- FULL: reached when boxes==MAX_BOXES with mode_wrap=0.
  - inc → counts unchanged, overflow=1 (sticky until reset or start_proc).
  - dec is ignored, since bottles==0 in FULL.
  - mode_wrap rising to 1 while in FULL → state=COUNT next cycle. The next box completion then wraps.
- Outputs:
  - All outputs are registered.
  - lot_full = (state==FULL).
  - Counts update on the same edge as the input, giving 1-cycle latency from inc to bottles.
  - box_done and lot_done assert on the cycle after the counting edge and last exactly 1 cycle.
- mode_wrap is sampled every cycle; changing it mid-lot affects only future box completions.
- Counts never leave the ranges 0..BOTTLES_PER_BOX-1 and 0..MAX_BOXES.

Optional Feature:
- Macro: INC_EDGE_DETECT_EN.
- Defined: inc and dec are treated as levels from the sensor. An internal register delays each by one cycle, and only a 0→1 transition counts. A high level held for N cycles counts once, and total count latency becomes 2 cycles. The delay registers clear on reset and start_proc.
- Not defined: every cycle with inc=1 (or dec=1) counts, as specified above.

Test Plan:
- Reset low mid-count (bottles=5, boxes=3) → all outputs 0 immediately, without waiting for clk; state=IDLE.
- mode_wrap=0, 108 inc pulses → after pulse 12 bottles=0, boxes=1 with box_done pulse. After pulse 108 boxes=9, lot_full=1, state=FULL. Pulse 109 → overflow=1, counts unchanged.
- mode_wrap=1, 120 inc pulses → at pulse 120 boxes=0, bottles=0, box_done and lot_done pulse in the same cycle; state=COUNT.
- bottles=3: dec ×4 → bottles 2,1,0,0, boxes unchanged. Same-cycle inc+dec at bottles=7 → stays 7.
- In FULL with overflow=1, assert start_proc and inc together → bottles=0, boxes=0, overflow=0, state=IDLE; the inc is not counted.
- With INC_EDGE_DETECT_EN: inc held high 10 cycles → bottles=1. Without the macro, the same stimulus → bottles=10.
